// File: rtl/denorm_shifter_pkg.sv
// Shared FPU definitions used by the denormalizing right shifter.
//   denorm_state_t : control states of the iterative shifter
//   GRS_BITS       : number of guard/round bits appended below the mantissa
package denorm_shifter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } denorm_state_t;

    localparam int GRS_BITS = 2;

endpackage

// File: rtl/denorm_shifter_sticky_shift_stage.sv
// sticky_shift_stage: combinational right shift of a W-bit vector by k
// (0..STRIDE), reporting the OR of every bit that falls off the bottom.
// Ports:
//   din        in  W       vector to shift
//   k          in  LEVELS  shift amount, never larger than STRIDE
//   dout       out W       din >> k
//   dropped_or out 1       OR of din[k-1:0]
// One mux level per bit of k, so log2(STRIDE)+1 levels in total; the top
// level is only taken for k == STRIDE.
module sticky_shift_stage #(
    parameter int W      = 34,
    parameter int STRIDE = 4,
    parameter int LEVELS = $clog2(STRIDE) + 1
) (
    input  logic [W-1:0]      din,
    input  logic [LEVELS-1:0] k,
    output logic [W-1:0]      dout,
    output logic              dropped_or
);

    // Binary-weighted shift levels; each level collects the bits it discards.
    always_comb begin
        dout       = din;
        dropped_or = 1'b0;
        for (int i = 0; i < LEVELS; i++) begin
            // Low (1<<i) bits of the current partial result are lost at this level.
            dropped_or = dropped_or | (k[i] & (|(dout & ~({W{1'b1}} << (32'd1 << i)))));
            dout       = k[i] ? (dout >> (32'd1 << i)) : dout;
        end
    end

endmodule

// File: rtl/denorm_shifter.sv
// denorm_shifter: iterative right-shift denormalizer with guard/round/sticky
// capture. Shifts at most STRIDE bits per cycle behind valid/ready handshakes.
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   InValid / InReady    request handshake (Num, ShiftAmt sampled on accept)
//   Num [WIDTH]          mantissa to denormalize
//   ShiftAmt [CBITS]     unsigned right-shift count
//   OutValid / OutReady  result handshake
//   Result [WIDTH]       shifted mantissa
//   Guard, Round, Sticky first dropped bit, second dropped bit, OR of the rest
module denorm_shifter
    import denorm_shifter_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int CBITS  = $clog2(WIDTH + 1),
    parameter int STRIDE = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] Num,
    input  logic [CBITS-1:0] ShiftAmt,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] Result,
    output logic             Guard,
    output logic             Round,
    output logic             Sticky
);

    localparam int EXT_W = WIDTH + GRS_BITS;
    localparam int RBITS = CBITS + 1;
    localparam int KBITS = $clog2(STRIDE) + 1;

    localparam logic [RBITS-1:0] MAX_SHIFT = RBITS'(EXT_W);
    localparam logic [RBITS-1:0] STRIDE_R  = RBITS'(STRIDE);

    denorm_state_t    state_q, state_d;
    logic [EXT_W-1:0] ext_q, ext_d;
    logic             sticky_q, sticky_d;
    logic [RBITS-1:0] rem_q, rem_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    logic [RBITS-1:0] amt_ext_s;
    logic [RBITS-1:0] amt_clamped_s;
    logic [KBITS-1:0] step_s;
    logic [RBITS-1:0] rem_next_s;
    logic [EXT_W-1:0] ext_shifted_s;
    logic             dropped_s;

    // Clamp the request amount: past EXT_W every bit is already gone, and the
    // sticky OR of the whole mantissa falls out of the normal iteration.
    always_comb begin
        amt_ext_s = {1'b0, ShiftAmt};
        if (amt_ext_s > MAX_SHIFT) begin
            amt_clamped_s = MAX_SHIFT;
        end else begin
            amt_clamped_s = amt_ext_s;
        end
    end

    // Per-cycle step k = min(STRIDE, remaining) and the remaining count after it.
    always_comb begin
        if (rem_q >= STRIDE_R) begin
            step_s = KBITS'(STRIDE);
        end else begin
            step_s = rem_q[KBITS-1:0];
        end
        rem_next_s = rem_q - {{(RBITS-KBITS){1'b0}}, step_s};
    end

    sticky_shift_stage #(
        .W      (EXT_W),
        .STRIDE (STRIDE)
    ) u_stage (
        .din        (ext_q),
        .k          (step_s),
        .dout       (ext_shifted_s),
        .dropped_or (dropped_s)
    );

    // Next-state and datapath update for the IDLE/SHIFT/DONE controller.
    always_comb begin
        state_d  = state_q;
        ext_d    = ext_q;
        sticky_d = sticky_q;
        rem_d    = rem_q;
        case (state_q)
            IDLE: begin
                // in_ready_q is low for the first cycle after reset release.
                if (InValid && in_ready_q) begin
                    ext_d    = {Num, {GRS_BITS{1'b0}}};
                    sticky_d = 1'b0;
                    rem_d    = amt_clamped_s;
                    if (amt_clamped_s == {RBITS{1'b0}}) begin
                        state_d = DONE;
                    end else begin
                        state_d = SHIFT;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                ext_d    = ext_shifted_s;
                sticky_d = sticky_q | dropped_s;
                rem_d    = rem_next_s;
                if (rem_next_s == {RBITS{1'b0}}) begin
                    state_d = DONE;
                end else begin
                    state_d = SHIFT;
                end
            end
            DONE: begin
                if (OutReady) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Handshake flags are registered copies of the upcoming state.
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    // State, datapath and handshake registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            ext_q       <= {EXT_W{1'b0}};
            sticky_q    <= 1'b0;
            rem_q       <= {RBITS{1'b0}};
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ext_q       <= ext_d;
            sticky_q    <= sticky_d;
            rem_q       <= rem_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign InReady  = in_ready_q;
    assign OutValid = out_valid_q;
    assign Result   = ext_q[EXT_W-1:GRS_BITS];
    assign Guard    = ext_q[1];
    assign Round    = ext_q[0];
    assign Sticky   = sticky_q;

endmodule

// File: tb/tb_denorm_shifter.sv
// Self-checking bench for denorm_shifter (WIDTH=32, STRIDE=4): directed
// scenarios plus randomized requests compared against a wide-shift reference
// model, with a leading-zero count check on normalized inputs.
module tb_denorm_shifter;

    localparam int WIDTH  = 32;
    localparam int CBITS  = 6;
    localparam int STRIDE = 4;
    localparam int EXT_W  = WIDTH + 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             InValid;
    logic             InReady;
    logic [WIDTH-1:0] Num;
    logic [CBITS-1:0] ShiftAmt;
    logic             OutValid;
    logic             OutReady;
    logic [WIDTH-1:0] Result;
    logic             Guard;
    logic             Round;
    logic             Sticky;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    denorm_shifter #(
        .WIDTH  (WIDTH),
        .CBITS  (CBITS),
        .STRIDE (STRIDE)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .InValid  (InValid),
        .InReady  (InReady),
        .Num      (Num),
        .ShiftAmt (ShiftAmt),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .Result   (Result),
        .Guard    (Guard),
        .Round    (Round),
        .Sticky   (Sticky)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Leading-zero counter used as the invariant checker on Result.
    function automatic int lzc(input logic [WIDTH-1:0] v);
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (v[i]) return WIDTH - 1 - i;
        end
        return WIDTH;
    endfunction

    // Reference: place Num at the top of a 128-bit word, shift by the clamped
    // amount, and read Result, G, R, S straight out of the wide value.
    function automatic void ref_model(input logic [WIDTH-1:0] num, input int sa,
                                      output logic [WIDTH-1:0] res, output logic g,
                                      output logic r, output logic s, output int lat);
        logic [127:0] big;
        int c;
        c   = (sa > EXT_W) ? EXT_W : sa;
        big = {num, 96'd0} >> c;
        res = big[127:96];
        g   = big[95];
        r   = big[94];
        s   = |big[93:0];
        lat = (c + STRIDE - 1) / STRIDE + 1;
    endfunction

    // Issue one request from a negedge, wait for the result, optionally stall
    // the consumer for 'hold' cycles, then complete the output handshake.
    task automatic run_req(input logic [WIDTH-1:0] num, input int sa, input int hold, input string tag);
        logic [WIDTH-1:0] er;
        logic eg, erg, es;
        int elat, lat, w;
        ref_model(num, sa, er, eg, erg, es, elat);
        w = 0;
        while (!InReady && w < 20) begin
            @(negedge clk);
            w++;
        end
        check_val({tag, "_inready"}, 64'(InReady), 64'd1);
        InValid  = 1'b1;
        Num      = num;
        ShiftAmt = sa[CBITS-1:0];
        @(posedge clk);
        @(negedge clk);
        InValid  = 1'b0;
        Num      = $urandom;
        ShiftAmt = CBITS'($urandom);
        check_val({tag, "_busy"}, 64'(InReady), 64'd0);
        lat = 1;
        while (!OutValid && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        check_val({tag, "_latency"}, 64'(lat), 64'(elat));
        check_val({tag, "_result"}, 64'(Result), 64'(er));
        check_val({tag, "_grs"}, 64'({Guard, Round, Sticky}), 64'({eg, erg, es}));
        if (num[WIDTH-1] && sa < WIDTH) begin
            check_val({tag, "_lzc"}, 64'(lzc(Result)), 64'(sa));
        end
        for (int i = 0; i < hold; i++) begin
            InValid  = 1'($urandom);
            Num      = $urandom;
            ShiftAmt = CBITS'($urandom);
            @(negedge clk);
            check_val({tag, "_hold_valid"}, 64'(OutValid), 64'd1);
            check_val({tag, "_hold_result"}, 64'(Result), 64'(er));
            check_val({tag, "_hold_grs"}, 64'({Guard, Round, Sticky}), 64'({eg, erg, es}));
            check_val({tag, "_hold_inready"}, 64'(InReady), 64'd0);
        end
        InValid  = 1'b0;
        OutReady = 1'b1;
        @(negedge clk);
        OutReady = 1'b0;
        check_val({tag, "_release_inready"}, 64'(InReady), 64'd1);
        check_val({tag, "_release_valid"}, 64'(OutValid), 64'd0);
    endtask

    initial begin
        reset    = 1'b1;
        InValid  = 1'b0;
        OutReady = 1'b0;
        Num      = '0;
        ShiftAmt = '0;
        #12;
        check_val("reset_inready", 64'(InReady), 64'd0);
        check_val("reset_outvalid", 64'(OutValid), 64'd0);
        check_val("reset_result", 64'(Result), 64'd0);
        check_val("reset_grs", 64'({Guard, Round, Sticky}), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_val("post_reset_inready", 64'(InReady), 64'd1);

        run_req(32'h8000_0000, 5, 0, "t1");
        run_req(32'h0000_000F, 3, 0, "t2");
        run_req(32'hDEAD_BEEF, 0, 0, "t3");
        run_req(32'h0000_0001, 40, 0, "t4");
        run_req(32'h1234_5678, 7, 5, "t5_bp");
        run_req(32'hC000_0003, 2, 0, "t5_next");

        // Reset during the second SHIFT cycle of a 20-bit shift.
        InValid  = 1'b1;
        Num      = 32'hFFFF_FFFF;
        ShiftAmt = 6'd20;
        @(posedge clk);
        @(negedge clk);
        InValid = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_val("t6_abort_valid", 64'(OutValid), 64'd0);
        check_val("t6_abort_result", 64'(Result), 64'd0);
        check_val("t6_abort_grs", 64'({Guard, Round, Sticky}), 64'd0);
        check_val("t6_abort_inready", 64'(InReady), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_val("t6_inready", 64'(InReady), 64'd1);
        check_val("t6_no_output", 64'(OutValid), 64'd0);
        run_req(32'h8000_0000, 1, 0, "t6_after");

        for (int n = 0; n < 150; n++) begin
            logic [WIDTH-1:0] rnum;
            rnum = $urandom;
            if ($urandom_range(0, 1) == 0) rnum[WIDTH-1] = 1'b1;
            run_req(rnum, int'($urandom_range(0, 63)), int'($urandom_range(0, 2)), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/denorm_shifter.md
# denorm_shifter

Iterative right-shift denormalizer with guard/round/sticky collection: the inverse of leading-zero counting. Given a mantissa and a shift count, it produces a result carrying exactly that many extra leading zeros and captures the bits shifted out as G/R/S for rounding. It sits in the FPU alignment and subnormal path, in front of the rounder. It trades latency for area by shifting at most STRIDE bits per cycle behind a valid/ready handshake.

## Interface
- WIDTH, 32: mantissa width in bits; must be ≥ 4.
- CBITS, $clog2(WIDTH+1): width of the shift-amount port.
- STRIDE, 4: maximum bits shifted per cycle; a power of 2 and ≤ WIDTH.
- clk  in  1  clock; one clock domain only.
- reset  in  1  asynchronous, active-high reset.
- InValid  in  1  request valid.
- InReady  out  1  block can accept a request.
- Num  in  WIDTH  mantissa to denormalize.
- ShiftAmt  in  CBITS  right-shift count, unsigned.
- OutValid  out  1  result valid.
- OutReady  in  1  consumer accepts the result.
- Result  out  WIDTH  shifted mantissa.
- Guard, Round, Sticky  out  1 each  first bit shifted out, second bit shifted out, OR of all later bits shifted out.

## Operation
- Internal extended register Ext = {Result, Guard, Round}, WIDTH+2 bits. Separate Sticky flop. Remaining counter is CBITS+1 bits.
- FSM states are IDLE, SHIFT and DONE.
- IDLE:
  - InReady = 1.
  - On InValid: load Ext = {Num, 2'b00}, Sticky = 0, Remaining = min(ShiftAmt, WIDTH+2).
  - Next state is DONE if the clamped amount is 0, else SHIFT.
- SHIFT:
  - Each cycle let k = min(STRIDE, Remaining).
  - Ext ← Ext >> k.
  - Sticky ← Sticky | OR(bits dropped off Ext[k-1:0]).
  - Remaining ← Remaining − k.
  - Go to DONE when Remaining − k == 0.
- DONE:
  - OutValid = 1; outputs are held stable.
  - On OutReady, go to IDLE.
- Shift amounts ≥ WIDTH+2 saturate: Result = 0, Guard = Round = 0, Sticky = OR(Num).
- Invariant: if Num[WIDTH-1] = 1 and ShiftAmt < WIDTH, then the leading-zero count of Result equals ShiftAmt.
- Only one request is in flight at a time. InReady is 0 in SHIFT and DONE.

## Timing
- Reset, asynchronous:
  - State becomes IDLE.
  - Ext, Sticky and Remaining become 0.
  - OutValid = 0 and Result = Guard = Round = Sticky = 0.
  - InReady = 0 while reset is high, and 1 from the first cycle after deassertion.
- Reset mid-SHIFT or mid-DONE aborts the request. No output handshake occurs for it.
- Latency from the accept edge to OutValid is ceil(clamp(ShiftAmt)/STRIDE) + 1 cycles. ShiftAmt = 0 gives 1 cycle.
- InReady and OutValid are decoded from registered state only. There is no combinational path from InValid or OutReady to either.
- Result, Guard, Round and Sticky are registered. They are defined only while OutValid = 1. They must not change while OutValid & ~OutReady.
- Completion: the DONE→IDLE handshake takes one cycle. InReady rises the cycle after OutValid & OutReady, so back-to-back throughput is latency + 1.
- InValid while InReady = 0 is ignored. Inputs are sampled only on the accept edge.

## Structure
- Shared FPU package holds:
  - typedef enum logic [1:0] {IDLE, SHIFT, DONE} denorm_state_t.
  - Constant GRS_BITS = 2 (extension width).
- Natural sub-module: sticky_shift_stage #(WIDTH+2, STRIDE).
  - Combinational right shift of Ext by k ∈ [0, STRIDE].
  - Returns the shifted vector plus the OR of the dropped bits.
  - Implemented as log2(STRIDE)+1 mux levels.
- The testbench instantiates the existing leading-zero counter as a checker on Result to verify the invariant.

## Test plan
All scenarios use WIDTH = 32, STRIDE = 4.
1. Num = 0x80000000, ShiftAmt = 5 → Result = 0x04000000, G/R/S = 0/0/0. OutValid 3 cycles after accept. LZC checker reads 5.
2. Num = 0x0000000F, ShiftAmt = 3 → Result = 0x00000001, G = 1, R = 1, S = 1.
3. Num = 0xDEADBEEF, ShiftAmt = 0 → Result = 0xDEADBEEF, G/R/S = 0. OutValid 1 cycle after accept.
4. Num = 0x00000001, ShiftAmt = 40 → Result = 0, G = 0, R = 0, S = 1. Nine SHIFT cycles, so OutValid 10 cycles after accept.
5. Backpressure: hold OutReady = 0 for 5 cycles in DONE → OutValid, Result and G/R/S stable; InReady = 0; a new InValid is ignored. Raise OutReady → InReady = 1 the next cycle, and the next request is accepted normally.
6. Assert reset during the 2nd SHIFT cycle of ShiftAmt = 20 → OutValid and all outputs go to 0 immediately. After deassertion InReady = 1, and a fresh request with Num = 0x80000000, ShiftAmt = 1 returns 0x40000000.
